// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix byte codes, frame states and the key event word.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  typedef struct packed {
    logic       toggle;
    logic       press;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  // Device responses and BAT results that never represent a key.
  function automatic logic is_response(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a saturating agreement counter; the output level
// only follows the pin after FILTER_LEN consecutive samples of the new value.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filters the pins, frames 11-bit packets and turns scancode
// streams (with E0/F0/E1 prefixes) into toggle-announced key events.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0] pin_raw;
  logic [1:0] pin_filt;
  logic       clk_f;
  logic       data_f;
  logic       clk_f_prev_reg;
  logic       fall;

  assign pin_raw = {ps2_data, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filter
      ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (pin_raw[gi]),
        .level (pin_filt[gi])
      );
    end
  endgenerate

  assign clk_f  = pin_filt[0];
  assign data_f = pin_filt[1];
  assign fall   = clk_f_prev_reg & ~clk_f;

  ps2_state_t     state_reg, state_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           parity_reg, parity_next;
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic           done_reg, done_next;
  logic           ok_reg, ok_next;
  logic           tmo_reg, tmo_next;

  logic           ext_reg;
  logic           rel_reg;
  logic [2:0]     skip_reg;
  ps2_key_t       key_reg;
  logic           frame_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_f_prev_reg <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      wdog_reg       <= '0;
      done_reg       <= 1'b0;
      ok_reg         <= 1'b0;
      tmo_reg        <= 1'b0;
    end else begin
      clk_f_prev_reg <= clk_f;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      wdog_reg       <= wdog_next;
      done_reg       <= done_next;
      ok_reg         <= ok_next;
      tmo_reg        <= tmo_next;
    end
  end

  // A fall always takes priority over the watchdog so a late-but-valid edge still counts.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    wdog_next    = wdog_reg + WDW'(1);
    done_next    = 1'b0;
    ok_next      = 1'b0;
    tmo_next     = 1'b0;
    if (state_reg == IDLE) begin
      wdog_next = '0;
    end
    if (fall) begin
      wdog_next = '0;
      case (state_reg)
        IDLE: begin
          if (!data_f) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_f, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = data_f;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          done_next  = 1'b1;
          ok_next    = data_f & (^{shift_reg, parity_reg});
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && wdog_reg == WDW'(TIMEOUT_CYC)) begin
      state_next = IDLE;
      wdog_next  = '0;
      tmo_next   = 1'b1;
    end
  end

  // Byte decoder: runs the cycle after a frame completes; shift_reg is stable while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_reg       <= 1'b0;
      rel_reg       <= 1'b0;
      skip_reg      <= '0;
      key_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= tmo_reg | (done_reg & ~ok_reg);
      if (done_reg) begin
        if (!ok_reg) begin
          ext_reg <= 1'b0;
          rel_reg <= 1'b0;
        end else if (skip_reg != 3'd0) begin
          skip_reg <= skip_reg - 3'd1;
        end else if (shift_reg == PS2_PAUSE) begin
          skip_reg <= 3'd7;
          ext_reg  <= 1'b0;
          rel_reg  <= 1'b0;
        end else if (shift_reg == PS2_EXT) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == PS2_REL) begin
          rel_reg <= 1'b1;
        end else if (!ext_reg && !rel_reg && is_response(shift_reg)) begin
          ext_reg <= 1'b0;
        end else begin
          key_reg <= '{toggle: ~key_reg.toggle, press: ~rel_reg,
                       ext: ext_reg, code: shift_reg};
          ext_reg <= 1'b0;
          rel_reg <= 1'b0;
        end
      end
    end
  end

  assign ps2_key   = key_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: bit-banged PS/2 frames with hand-computed key words.
module tb_ps2_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  logic tog_prev = 1'b0;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      tog_prev <= 1'b0;
    end else begin
      if (ps2_key[10] != tog_prev) ev_cnt <= ev_cnt + 1;
      tog_prev <= ps2_key[10];
      if (frame_err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; glitch_at inserts a short clock glitch before that bit.
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop,
                            input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) begin
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
      end
      send_bit(fr[i]);
    end
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11, -1);
  endtask

  int ev0;

  initial begin
    repeat (5) @(negedge clk);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 1: plain make code
    frame(8'h1C);
    check("t1_key", 32'(ps2_key), 32'h61C);
    check("t1_events", 32'(ev_cnt), 32'd1);
    check("t1_errs", 32'(err_cnt), 32'd0);

    // 2: break and extended break
    frame(8'hF0);
    check("t2_prefix", 32'(ev_cnt), 32'd1);
    frame(8'h1C);
    check("t2_brk_key", 32'(ps2_key), 32'h01C);
    check("t2_brk_ev", 32'(ev_cnt), 32'd2);
    frame(8'hE0);
    frame(8'hF0);
    check("t2_pfx2", 32'(ev_cnt), 32'd2);
    frame(8'h75);
    check("t2_ext_key", 32'(ps2_key), 32'h575);
    check("t2_ext_ev", 32'(ev_cnt), 32'd3);

    // 3: parity error clears the pending prefix; bad stop bit also flagged
    frame(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    check("t3_par_err", 32'(err_cnt), 32'd1);
    check("t3_key_hold", 32'(ps2_key), 32'h575);
    frame(8'h16);
    check("t3_next_key", 32'(ps2_key), 32'h216);
    check("t3_next_ev", 32'(ev_cnt), 32'd4);
    send_frame(8'h22, 1'b0, 1'b0, 11, -1);
    check("t3_stop_err", 32'(err_cnt), 32'd2);
    check("t3_stop_key", 32'(ps2_key), 32'h216);

    // 4: pause sequence produces nothing; device response ignored
    ev0 = ev_cnt;
    frame(8'hE1); frame(8'h14); frame(8'h77); frame(8'hE1);
    frame(8'hF0); frame(8'h14); frame(8'hF0); frame(8'h77);
    check("t4_pause_ev", 32'(ev_cnt - ev0), 32'd0);
    frame(8'h29);
    check("t4_key", 32'(ps2_key), 32'h629);
    frame(8'hAA);
    check("t4_bat_ev", 32'(ev_cnt - ev0), 32'd1);

    // 5: truncated frame times out once
    send_frame(8'h55, 1'b0, 1'b1, 5, -1);
    repeat (300) @(negedge clk);
    check("t5_pre_tmo", 32'(err_cnt), 32'd2);
    repeat (150) @(negedge clk);
    check("t5_tmo_err", 32'(err_cnt), 32'd3);
    frame(8'h1C);
    check("t5_after_key", 32'(ps2_key), 32'h21C);

    // 6: short clock glitch is filtered out
    send_frame(8'h16, 1'b0, 1'b1, 11, 4);
    check("t6_glitch_key", 32'(ps2_key), 32'h616);
    check("t6_glitch_err", 32'(err_cnt), 32'd3);

    // 6: reset in the middle of a frame
    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("t6_rst_key", 32'(ps2_key), 32'h000);
    repeat (100) @(negedge clk);
    check("t6_rst_hold", 32'(ps2_key), 32'h000);
    check("t6_rst_err", 32'(frame_err), 32'h0);
    frame(8'h1C);
    check("t6_post_key", 32'(ps2_key), 32'h61C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
